// File: rtl/cycle_offset_monitor_if.sv
// Signal bundle of the cycle_offset_monitor: environment controls (en, input_x,
// new_input) plus the HLC/LLC status and stream results.
interface cycle_offset_monitor_if #(
  parameter int DATA_W = 64
);
  logic              en;
  logic [DATA_W-1:0] input_x;
  logic              new_input;
  logic              hlc_clock;
  logic [DATA_W-1:0] hlc_x;
  logic              hlc_enA;
  logic              hlc_enB;
  logic              hlc_enC;
  logic [DATA_W-1:0] llc_stage;
  logic [DATA_W-1:0] output_a;
  logic              output_a_aktv;
  logic [DATA_W-1:0] output_b;
  logic              output_b_aktv;
  logic [DATA_W-1:0] output_c;
  logic              output_c_aktv;

  modport master (
    output en, input_x, new_input,
    input  hlc_clock, hlc_x, hlc_enA, hlc_enB, hlc_enC, llc_stage,
    input  output_a, output_a_aktv, output_b, output_b_aktv,
    input  output_c, output_c_aktv
  );

  modport slave (
    input  en, input_x, new_input,
    output hlc_clock, hlc_x, hlc_enA, hlc_enB, hlc_enC, llc_stage,
    output output_a, output_a_aktv, output_b, output_b_aktv,
    output output_c, output_c_aktv
  );
endinterface

// File: rtl/cycle_offset_monitor.sv
// RTLola monitor for a := x + c[-1|0], b := a + 1, c := b + x.
// One event is accepted at stage 0 and evaluated over the following LLC stages.
module cycle_offset_monitor #(
  parameter int DATA_W  = 64,
  parameter int N_STAGE = 5
) (
  input logic                   clk,
  input logic                   rst,
  cycle_offset_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    ST_0 = 3'd0,
    ST_1 = 3'd1,
    ST_2 = 3'd2,
    ST_3 = 3'd3,
    ST_4 = 3'd4
  } stage_t;

  localparam stage_t LAST_STAGE = stage_t'(N_STAGE - 1);

  stage_t            stage_q, stage_d;
  logic              accept, eval_a, eval_b, eval_c, commit_c;

  logic              hlc_clock_q;
  logic [DATA_W-1:0] x_q;
  logic              en_a_q, en_b_q, en_c_q;
  logic [DATA_W-1:0] a_q, b_q, c_q, c_hist_q;
  logic              a_aktv_q, b_aktv_q, c_aktv_q;

  always_ff @(posedge clk) begin
    if (!rst)        stage_q <= ST_0;
    else if (bus.en) stage_q <= stage_d;
  end

  always_comb begin
    stage_d  = ST_0;
    case (stage_q)
      ST_0:    stage_d = ST_1;
      ST_1:    stage_d = ST_2;
      ST_2:    stage_d = ST_3;
      ST_3:    stage_d = ST_4;
      default: stage_d = ST_0;
    endcase
    if (stage_q == LAST_STAGE) stage_d = ST_0;

    accept   = (stage_q == ST_0);
    eval_a   = (stage_q == ST_1) && en_a_q;
    eval_b   = (stage_q == ST_2) && en_b_q;
    eval_c   = (stage_q == ST_3) && en_c_q;
    commit_c = (stage_q == ST_4) && en_c_q;
  end

  // Two's complement addition wraps identically for signed and unsigned data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hlc_clock_q <= 1'b0;
      x_q         <= '0;
      en_a_q      <= 1'b0;
      en_b_q      <= 1'b0;
      en_c_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      c_hist_q    <= '0;
      a_aktv_q    <= 1'b0;
      b_aktv_q    <= 1'b0;
      c_aktv_q    <= 1'b0;
    end else if (bus.en) begin
      hlc_clock_q <= 1'b0;
      if (accept) begin
        x_q         <= bus.input_x;
        en_a_q      <= bus.new_input;
        en_b_q      <= bus.new_input;
        en_c_q      <= bus.new_input;
        hlc_clock_q <= bus.new_input;
        a_aktv_q    <= 1'b0;
        b_aktv_q    <= 1'b0;
        c_aktv_q    <= 1'b0;
      end
      if (eval_a) begin
        a_q      <= x_q + c_hist_q;
        a_aktv_q <= 1'b1;
      end
      if (eval_b) begin
        b_q      <= a_q + DATA_W'(1);
        b_aktv_q <= 1'b1;
      end
      if (eval_c) begin
        c_q      <= b_q + x_q;
        c_aktv_q <= 1'b1;
      end
      // History is committed only after c of this event is final, so a never sees it early.
      if (commit_c) c_hist_q <= c_q;
    end
  end

  assign bus.hlc_clock     = hlc_clock_q;
  assign bus.hlc_x         = x_q;
  assign bus.hlc_enA       = en_a_q;
  assign bus.hlc_enB       = en_b_q;
  assign bus.hlc_enC       = en_c_q;
  assign bus.llc_stage     = {{(DATA_W-3){1'b0}}, stage_q};
  assign bus.output_a      = a_q;
  assign bus.output_a_aktv = a_aktv_q;
  assign bus.output_b      = b_q;
  assign bus.output_b_aktv = b_aktv_q;
  assign bus.output_c      = c_q;
  assign bus.output_c_aktv = c_aktv_q;

endmodule

// File: tb/tb_cycle_offset_monitor.sv
// Scoreboard bench for cycle_offset_monitor: a stream-level model predicts
// (a,b,c) per event and per-cycle control state; a monitor compares them.
module tb_cycle_offset_monitor;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
  } exp_t;

  logic clk;
  logic rst;

  cycle_offset_monitor_if #(.DATA_W(64)) bus ();

  cycle_offset_monitor #(.DATA_W(64), .N_STAGE(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] c_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream semantics: a uses c of the previous event (default 0).
  task automatic push_model(input logic [63:0] x);
    exp_t e;
    e.a = x + c_prev;
    e.b = e.a + 64'd1;
    e.c = e.b + x;
    c_prev = e.c;
    sb.push_back(e);
  endtask

  task automatic push_const(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
    exp_t e;
    e.a = a; e.b = b; e.c = c;
    c_prev = c;
    sb.push_back(e);
  endtask

  // Per-cycle control model: stage counter, current event enable, latched x, pulse.
  logic [2:0]  m_stage = '0;
  logic        m_ev    = 1'b0;
  logic [63:0] m_x     = '0;
  logic        m_clk   = 1'b0;
  logic        started = 1'b0;

  always @(posedge clk) begin
    started <= 1'b1;
    if (!rst) begin
      m_stage <= '0;
      m_ev    <= 1'b0;
      m_x     <= '0;
      m_clk   <= 1'b0;
    end else if (bus.en) begin
      m_stage <= (m_stage == 3'd4) ? 3'd0 : m_stage + 3'd1;
      m_clk   <= (m_stage == 3'd0) && bus.new_input;
      if (m_stage == 3'd0) begin
        m_ev <= bus.new_input;
        m_x  <= bus.input_x;
      end
    end
  end

  logic prev_c_aktv = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      chk("llc_stage", bus.llc_stage, 64'(m_stage));
      chk("hlc_clock", 64'(bus.hlc_clock), 64'(m_clk));
      chk("hlc_x",     bus.hlc_x, m_x);
      chk("hlc_enA",   64'(bus.hlc_enA), 64'(m_ev));
      chk("hlc_enB",   64'(bus.hlc_enB), 64'(m_ev));
      chk("hlc_enC",   64'(bus.hlc_enC), 64'(m_ev));
      chk("a_aktv", 64'(bus.output_a_aktv), 64'(m_ev && (m_stage != 3'd1)));
      chk("b_aktv", 64'(bus.output_b_aktv), 64'(m_ev && (m_stage >= 3'd3 || m_stage == 3'd0)));
      chk("c_aktv", 64'(bus.output_c_aktv), 64'(m_ev && (m_stage == 3'd4 || m_stage == 3'd0)));
      if (bus.output_c_aktv && !prev_c_aktv) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got c=%h expected no event", bus.output_c);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("output_a", bus.output_a, e.a);
          chk("output_b", bus.output_b, e.b);
          chk("output_c", bus.output_c, e.c);
        end
      end
      prev_c_aktv = bus.output_c_aktv;
    end
  end

  task automatic wait_stage(input int s);
    int n;
    n = 0;
    while (bus.llc_stage != 64'(s) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) begin
      checks++;
      errors++;
      $display("FAIL wait_stage: got stage %0d expected %0d", bus.llc_stage, s);
    end
  endtask

  // One HLC slot; inputs scribbled at non-zero stages; optional 3-cycle en drop.
  task automatic slot(input logic [63:0] x, input bit valid, input bit use_model, input int drop);
    int n;
    bit dropped;
    wait_stage(0);
    bus.input_x   = x;
    bus.new_input = valid;
    if (valid && use_model) push_model(x);
    @(negedge clk);
    n = 0;
    dropped = 1'b0;
    while (bus.llc_stage != 64'd0 && n < 30) begin
      if (!dropped && drop >= 0 && bus.llc_stage == 64'(drop)) begin
        bus.en = 1'b0;
        repeat (3) @(negedge clk);
        bus.en = 1'b1;
        dropped = 1'b1;
      end else begin
        bus.input_x   = {$urandom, $urandom};
        bus.new_input = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      n++;
    end
  endtask

  task automatic do_reset(input int cycles, input logic en_val);
    rst    = 1'b0;
    bus.en = en_val;
    sb.delete();
    c_prev = '0;
    repeat (cycles) @(negedge clk);
    chk("reset_a", bus.output_a, 64'd0);
    chk("reset_b", bus.output_b, 64'd0);
    chk("reset_c", bus.output_c, 64'd0);
    rst    = 1'b1;
    bus.en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] tbl_a[6] = '{64'd1, 64'd5, 64'd11, 64'd19, 64'd29, 64'd41};
    logic [63:0] tbl_b[6] = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd30, 64'd42};
    logic [63:0] tbl_c[6] = '{64'd3, 64'd8, 64'd15, 64'd24, 64'd35, 64'd48};
    rst           = 1'b0;
    bus.en        = 1'b1;
    bus.input_x   = '0;
    bus.new_input = 1'b0;
    @(negedge clk);
    do_reset(3, 1'b1);

    for (int unsigned i = 0; i < 6; i++) begin
      push_const(tbl_a[i], tbl_b[i], tbl_c[i]);
      slot(64'(i + 1), 1'b1, 1'b0, -1);
    end

    slot(64'd99, 1'b0, 1'b1, -1);
    push_const(64'd55, 64'd56, 64'd63);
    slot(64'd7, 1'b1, 1'b0, -1);
    slot(64'd10, 1'b1, 1'b1, 2);

    for (int unsigned i = 0; i < 40; i++) begin
      int drop;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
      slot({$urandom, $urandom}, ($urandom_range(0, 3) != 0), 1'b1, drop);
    end

    // Reset in the middle of an event (stage 3) while en is low.
    wait_stage(0);
    bus.input_x   = 64'd5;
    bus.new_input = 1'b1;
    @(negedge clk);
    wait_stage(3);
    do_reset(3, 1'b0);
    push_const(64'd1, 64'd2, 64'd3);
    slot(64'd1, 1'b1, 1'b0, -1);
    slot(64'd2, 1'b1, 1'b1, -1);

    do_reset(2, 1'b1);
    push_const(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    slot(64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, -1);
    slot(64'd3, 1'b1, 1'b1, -1);

    slot(64'd0, 1'b0, 1'b1, -1);
    slot(64'd0, 1'b0, 1'b1, -1);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
